// File: rtl/mux3_arb_pkg.sv
// Shared types and constants for the MUX3 round-robin burst arbiter.
package mux3_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int REQ_D0 = 0;
  localparam int REQ_D1 = 1;
  localparam int REQ_D2 = 2;

  localparam int CNT_W = 8;

  // Advance a requester index modulo 3 (2 wraps to 0).
  function automatic logic [1:0] idx_inc(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mux3_rr_arb_pick.sv
// Combinational round-robin picker: first requester with req high,
// scanning ptr, ptr+1, ptr+2 (mod 3).
module rr_pick3
  import mux3_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] win_o,
  output logic [1:0] win_idx_o
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    win_idx_o = 2'd0;
    found     = 1'b0;
    cand      = (ptr_i > 2'd2) ? 2'd0 : ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        win_idx_o = cand;
      end
      cand = idx_inc(cand);
    end
  end

  always_comb begin
    win_o = 3'b000;
    if (found) begin
      win_o[win_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mux3_rr_arb.sv
// Round-robin burst arbiter driving the s0/s1 selects of one MUX3 datapath.
//   state   | meaning
//   ST_IDLE | no owner; arbitrate among req_i this cycle
//   ST_BUSY | gnt_q owns the mux until last beat or MAX_BEAT transfers
module mux3_rr_arb
  import mux3_arb_pkg::*;
#(
  parameter int MAX_BEAT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [2:0] req_i,
  input  logic [2:0] last_i,
  input  logic       out_ready_i,
  output logic [2:0] gnt_o,
  output logic       s0_o,
  output logic       s1_o,
  output logic       out_valid_o,
  output logic       trunc_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEAT - 1);

  state_e           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;

  logic [2:0] win;
  logic [1:0] win_idx;
  logic       xfer;
  logic       last_g;
  logic       at_limit;

  rr_pick3 u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  assign out_valid_o = |(gnt_q & req_i);
  assign xfer        = out_valid_o && out_ready_i;
  assign last_g      = |(gnt_q & last_i);
  assign at_limit    = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_BUSY;
          gnt_d   = win;
          ptr_d   = idx_inc(win_idx);
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (xfer) begin
          if (last_g || at_limit) begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
            cnt_d   = '0;
            // A burst that ends on its own last beat is never a truncation.
            trunc_d = !last_g;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= 3'b000;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign s0_o    = gnt_q[REQ_D0];
  assign s1_o    = gnt_q[REQ_D1];
  assign trunc_o = trunc_q;

endmodule

// File: tb/tb_mux3_rr_arb.sv
// Bench for mux3_rr_arb: directed scenarios plus random traffic, all checked
// against a burst-level reference model (owner index, beats done, next start).
module tb_mux3_rr_arb;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req, last;
  logic       out_ready;
  logic [2:0] gnt;
  logic       s0, s1, out_valid, trunc;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: -1 means nobody owns the mux.
  int   m_owner = -1;
  int   m_next  = 0;
  int   m_beats = 0;
  logic m_trunc = 1'b0;

  int dut_xfers  = 0;
  int dut_truncs = 0;

  always #5 clk = ~clk;

  mux3_rr_arb #(.MAX_BEAT(MB)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .last_i      (last),
    .out_ready_i (out_ready),
    .gnt_o       (gnt),
    .s0_o        (s0),
    .s1_o        (s1),
    .out_valid_o (out_valid),
    .trunc_o     (trunc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input int o);
    logic [2:0] v;
    v = 3'b000;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  // Burst-level behaviour applied at each rising edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_owner = -1; m_next = 0; m_beats = 0; m_trunc = 1'b0;
    end else if (m_owner < 0) begin
      m_trunc = 1'b0;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (m_next + k) % 3;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_next  = (m_owner + 1) % 3;
        m_beats = 0;
      end
    end else begin
      m_trunc = 1'b0;
      if (req[m_owner] && out_ready) begin
        m_beats++;
        if (last[m_owner] || m_beats == MB) begin
          m_trunc = !last[m_owner];
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [2:0] q, input logic [2:0] l, input logic rdy);
    logic [2:0] eg;
    rst_n = r; req = q; last = l; out_ready = rdy;
    @(negedge clk);
    eg = onehot(m_owner);
    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    chk("s0", {31'd0, s0}, {31'd0, eg[0]});
    chk("s1", {31'd0, s1}, {31'd0, eg[1]});
    chk("out_valid", {31'd0, out_valid}, {31'd0, |(eg & q)});
    chk("trunc", {31'd0, trunc}, {31'd0, m_trunc});
    chk("sel_excl", {31'd0, s0 & s1}, 32'd0);
    if (out_valid && out_ready) dut_xfers++;
    if (trunc) dut_truncs++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Drive an owned burst; last asserted on beat nb (nb=0: never).
  task automatic run_burst(input logic [2:0] q, input int nb);
    for (int i = 0; i < 20 && m_owner >= 0; i++) begin
      step(1'b1, q, (nb > 0 && m_beats == nb - 1) ? 3'b111 : 3'b000, 1'b1);
    end
    chk("burst_end_gnt", {29'd0, gnt}, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b0, 3'b000, 3'b000, 1'b0);
  endtask

  logic [2:0] order [4];

  initial begin
    rst_n = 1'b0; req = 3'b111; last = 3'b000; out_ready = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Reset held with all requesters active, then first grant.
    step(1'b0, 3'b111, 3'b000, 1'b1);
    step(1'b0, 3'b111, 3'b000, 1'b1);
    step(1'b1, 3'b111, 3'b000, 1'b1);
    chk("rst_first_gnt", {29'd0, gnt}, 32'h1);
    do_reset();

    // Single 3-beat burst from requester 1, then ptr should favour 2.
    step(1'b1, 3'b010, 3'b000, 1'b1);
    chk("single_gnt", {29'd0, gnt}, 32'h2);
    dut_xfers = 0;
    run_burst(3'b010, 3);
    chk("single_beats", dut_xfers, 32'd3);
    step(1'b1, 3'b111, 3'b000, 1'b1);
    chk("single_ptr2", {29'd0, gnt}, 32'h4);
    do_reset();

    // Fairness with 2-beat bursts.
    for (int b = 0; b < 4; b++) begin
      step(1'b1, 3'b111, 3'b000, 1'b1);
      order[b] = gnt;
      run_burst(3'b111, 2);
    end
    chk("fair0", {29'd0, order[0]}, 32'h1);
    chk("fair1", {29'd0, order[1]}, 32'h2);
    chk("fair2", {29'd0, order[2]}, 32'h4);
    chk("fair3", {29'd0, order[3]}, 32'h1);
    do_reset();

    // Truncation at MAX_BEAT, then last coinciding with the limit.
    dut_xfers = 0; dut_truncs = 0;
    step(1'b1, 3'b100, 3'b000, 1'b1);
    run_burst(3'b100, 0);
    step(1'b1, 3'b000, 3'b000, 1'b1);
    chk("trunc_beats", dut_xfers, 32'd4);
    chk("trunc_pulses", dut_truncs, 32'd1);
    dut_xfers = 0; dut_truncs = 0;
    step(1'b1, 3'b100, 3'b000, 1'b1);
    run_burst(3'b100, 4);
    step(1'b1, 3'b000, 3'b000, 1'b1);
    chk("last_lim_beats", dut_xfers, 32'd4);
    chk("last_lim_pulses", dut_truncs, 32'd0);
    do_reset();

    // Stalls: ready low 5 cycles, then req[0] dropped 2 cycles, 3-beat burst.
    dut_xfers = 0;
    step(1'b1, 3'b001, 3'b000, 1'b1);
    step(1'b1, 3'b001, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 3'b111, 3'b111, 1'b0);
    chk("stall_gnt", {29'd0, gnt}, 32'h1);
    for (int i = 0; i < 2; i++) step(1'b1, 3'b110, 3'b111, 1'b1);
    chk("drop_gnt", {29'd0, gnt}, 32'h1);
    run_burst(3'b001, 3);
    chk("stall_beats", dut_xfers, 32'd3);
    do_reset();

    // Reset mid-burst on beat 2 of requester 1.
    step(1'b1, 3'b010, 3'b000, 1'b1);
    step(1'b1, 3'b010, 3'b000, 1'b1);
    step(1'b0, 3'b010, 3'b000, 1'b1);
    chk("midrst_gnt", {29'd0, gnt}, 32'd0);
    step(1'b1, 3'b011, 3'b000, 1'b1);
    chk("midrst_regrant", {29'd0, gnt}, 32'h1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) != 0,
           3'($urandom),
           ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
